approx_mul_iter: RTL and testbench

//   Parametrised iterative unsigned multiplier with a run-time exact/approximate mode.

---
 rtl/approx_mul_iter_if.sv | 25 ++
 rtl/approx_mul_iter.sv | 111 +++++++++++
 tb/tb_approx_mul_iter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/approx_mul_iter_if.sv
// Valid/ready operand and result stream for approx_mul_iter.
// The master drives operands and out_ready; the slave (the multiplier) answers.
interface approx_mul_iter_if #(
  parameter int WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_approx;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_prod;
  logic [2*WIDTH-1:0]   out_err;

  modport master (
    output in_valid, in_a, in_b, in_approx, out_ready,
    input  in_ready, out_valid, out_prod, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_approx, out_ready,
    output in_ready, out_valid, out_prod, out_err
  );
endinterface

// File: rtl/approx_mul_iter.sv
// Iterative shift-add unsigned multiplier. It computes exact and column-truncated
// products together, one multiplier bit per cycle, and reports and counts the error.
module approx_mul_iter #(
  parameter int WIDTH = 4,
  parameter int TRUNC = 3,
  parameter int ET    = 8,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  approx_mul_iter_if.slave  bus,
  output logic              err_flag,
  output logic [CNT_W-1:0]  err_count,
  input  logic              count_clr
);

  localparam int P_W   = 2 * WIDTH;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  // A shift by TRUNC >= P_W yields all zeros, so the approximate product becomes 0.
  localparam logic [P_W-1:0] KEEP_MASK = {P_W{1'b1}} << TRUNC;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              approx_q;
  logic [IDX_W-1:0]  idx_q;
  logic [P_W-1:0]    exact_acc, approx_acc;
  logic [P_W-1:0]    prod_q, err_q;
  logic              flag_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [P_W-1:0]    pp_row;
  logic [P_W-1:0]    exact_nxt, approx_nxt, diff_nxt;
  logic              accept, deliver, last_bit;

  assign accept   = (state_q == IDLE) && bus.in_valid;
  assign deliver  = (state_q == DONE) && bus.out_ready;
  assign last_bit = (idx_q == LAST_IDX);

  // Truncated rows never exceed the full rows, so diff_nxt cannot wrap.
  assign pp_row     = b_q[idx_q] ? (P_W'(a_q) << idx_q) : '0;
  assign exact_nxt  = exact_acc + pp_row;
  assign approx_nxt = approx_acc + (pp_row & KEEP_MASK);
  assign diff_nxt   = exact_nxt - approx_nxt;

  // NOTE: every output of a combinational block gets a default before the case,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = BUSY;
      BUSY:    if (last_bit)      state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      approx_q   <= 1'b0;
      idx_q      <= '0;
      exact_acc  <= '0;
      approx_acc <= '0;
      prod_q     <= '0;
      err_q      <= '0;
      flag_q     <= 1'b0;
    end else if (accept) begin
      a_q        <= bus.in_a;
      b_q        <= bus.in_b;
      approx_q   <= bus.in_approx;
      idx_q      <= '0;
      exact_acc  <= '0;
      approx_acc <= '0;
    end else if (state_q == BUSY) begin
      exact_acc  <= exact_nxt;
      approx_acc <= approx_nxt;
      idx_q      <= idx_q + 1'b1;
      if (last_bit) begin
        prod_q <= approx_q ? approx_nxt : exact_nxt;
        err_q  <= approx_q ? diff_nxt : '0;
        flag_q <= approx_q && (64'(diff_nxt) > 64'(ET));
      end
    end
  end

  // Clear wins over a same-cycle flagged delivery; the count sticks at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               cnt_q <= '0;
    else if (count_clr)                       cnt_q <= '0;
    else if (deliver && flag_q && ~&cnt_q)    cnt_q <= cnt_q + 1'b1;
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_prod  = prod_q;
  assign bus.out_err   = err_q;
  assign err_flag      = flag_q;
  assign err_count     = cnt_q;

endmodule

// File: tb/tb_approx_mul_iter.sv
// Self-checking bench for approx_mul_iter: directed corner cases plus random
// operands checked against a partial-product bit-matrix reference model.
module tb_approx_mul_iter;

  localparam int WIDTH = 4;
  localparam int TRUNC = 3;
  localparam int ET    = 8;
  localparam int CNT_W = 8;
  localparam int P_W   = 2 * WIDTH;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             count_clr;
  logic             err_flag;
  logic [CNT_W-1:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  approx_mul_iter_if #(.WIDTH(WIDTH)) bus ();

  approx_mul_iter #(
    .WIDTH(WIDTH), .TRUNC(TRUNC), .ET(ET), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .err_flag  (err_flag),
    .err_count (err_count),
    .count_clr (count_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: sum every a[i]&b[j] dot at column i+j, dropping columns below TRUNC.
  task automatic model(input int a, input int b, input bit ap,
                       output int prod, output int err, output bit flag);
    int exact, approx;
    exact  = a * b;
    approx = 0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
        if (a[i] && b[j] && (i + j) >= TRUNC) approx += (1 << (i + j));
    prod = ap ? approx : exact;
    err  = ap ? exact - approx : 0;
    flag = (err > ET);
  endtask

  task automatic run_op(input int a, input int b, input bit ap,
                        input int hold, input bit clr, input bit full_check);
    int  e_prod, e_err, lat;
    bit  e_flag;
    model(a, b, ap, e_prod, e_err, e_flag);

    @(negedge clk);
    bus.in_a      = WIDTH'(a);
    bus.in_b      = WIDTH'(b);
    bus.in_approx = ap;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    if (full_check) check("in_ready_idle", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.in_a      = WIDTH'($urandom);
    bus.in_b      = WIDTH'($urandom);
    bus.in_approx = ~ap;

    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (full_check) check("latency", lat, WIDTH);
    check("out_prod", bus.out_prod, e_prod);
    check("out_err", bus.out_err, e_err);
    check("err_flag", err_flag, e_flag);
    if (full_check) check("in_ready_done", bus.in_ready, 0);

    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = WIDTH'($urandom);
      bus.in_b     = WIDTH'($urandom);
      @(posedge clk); #1;
      check("hold_valid", bus.out_valid, 1);
      check("hold_prod", bus.out_prod, e_prod);
      check("hold_err", bus.out_err, e_err);
      check("hold_in_ready", bus.in_ready, 0);
    end

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    count_clr     = clr;
    @(posedge clk);
    if (clr)                              exp_cnt = 0;
    else if (e_flag && exp_cnt < CNT_MAX) exp_cnt++;
    #1;
    bus.out_ready = 1'b0;
    count_clr     = 1'b0;
    check("err_count", err_count, exp_cnt);
    if (full_check) begin
      check("valid_after_hs", bus.out_valid, 0);
      check("in_ready_after_hs", bus.in_ready, 1);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    count_clr     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_approx = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_prod", bus.out_prod, 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_err_flag", err_flag, 0);
    check("rst_err_count", err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(15, 15, 1'b0, 0, 1'b0, 1'b1);
    check("exact_15x15_err", bus.out_err, 0);
    run_op(15, 15, 1'b1, 0, 1'b0, 1'b1);
    check("count_after_first_flag", err_count, 1);
    run_op(5, 3, 1'b1, 0, 1'b0, 1'b1);
    run_op(0, 9, 1'b0, 0, 1'b0, 1'b1);
    run_op(0, 9, 1'b1, 0, 1'b0, 1'b1);
    run_op(15, 15, 1'b1, 6, 1'b0, 1'b1);

    // Random operands and modes
    for (int k = 0; k < 40; k++)
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             1'($urandom), int'($urandom_range(0, 2)), 1'b0, 1'b1);

    // Abort during the second BUSY cycle
    @(negedge clk);
    bus.in_a = 4'd9; bus.in_b = 4'd11; bus.in_approx = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n   = 1'b0;
    exp_cnt = 0;
    #1;
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_out_prod", bus.out_prod, 0);
    check("abort_out_err", bus.out_err, 0);
    check("abort_err_flag", err_flag, 0);
    check("abort_err_count", err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("abort_no_result", bus.out_valid, 0);
    end
    run_op(7, 7, 1'b0, 0, 1'b0, 1'b1);
    check("post_abort_7x7", bus.out_prod, 49);

    // Saturation, then clear colliding with a flagged delivery
    for (int k = 0; k < 260; k++)
      run_op(15, 15, 1'b1, 0, 1'b0, 1'b0);
    check("count_saturated", err_count, CNT_MAX);
    run_op(15, 15, 1'b1, 0, 1'b0, 1'b0);
    check("count_stays_saturated", err_count, CNT_MAX);
    run_op(15, 15, 1'b1, 0, 1'b1, 1'b1);
    check("clr_beats_increment", err_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
